page_rank_sorter: RTL and testbench

Downstream of `pageRank`, this block ranks the converged node values. It captures a snapshot of all N node values through a valid/ready handshake. It then sorts them in descending order with an odd-even transposition network that runs one phase per cycle. It presents the sorted values together with their original node indices, so the ranking can be read out or forwarded.

---
 rtl/page_rank_pkg.sv | 29 ++
 rtl/page_rank_sorter_if.sv | 40 ++++
 rtl/page_rank_cmp_swap.sv | 18 +
 rtl/page_rank_sorter.sv | 122 ++++++++++++
 tb/tb_page_rank_sorter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/page_rank_pkg.sv
// Shared types and constants for the page-rank datapath.
// Slots are sized for the widest value/index any stage carries.
package page_rank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } sort_state_t;

  localparam int FRAC_BITS = 16;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] DAMPING = 32'h0000_D99A;

  localparam int SLOT_VW = 32;
  localparam int SLOT_IW = 8;

  typedef struct packed {
    logic [SLOT_VW-1:0] value;
    logic [SLOT_IW-1:0] index;
  } slot_t;

  // b belongs in front of a: larger value, or equal value and lower index
  function automatic logic slot_before(slot_t a, slot_t b);
    return (b.value > a.value) ||
           ((b.value == a.value) && (b.index < a.index));
  endfunction

endpackage

// File: rtl/page_rank_sorter_if.sv
// Snapshot-in / ranking-out handshake bundle for page_rank_sorter.
// The master side drives snapshots and consumes results.
interface page_rank_sorter_if #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
);

  logic                in_valid;
  logic                in_ready;
  logic [N*WIDTH-1:0]  node_vals;
  logic                out_valid;
  logic                out_ready;
  logic [N*WIDTH-1:0]  sorted_vals;
  logic [N*IDXW-1:0]   sorted_idx;
  logic                busy;

  modport master (
    output in_valid,
    output node_vals,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sorted_vals,
    input  sorted_idx,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  node_vals,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sorted_vals,
    output sorted_idx,
    output busy
  );

endinterface

// File: rtl/page_rank_cmp_swap.sv
// One compare-exchange cell: first gets the higher-ranked slot.
// Ties on value go to the lower original index.
module page_rank_cmp_swap
  import page_rank_pkg::*;
(
  input  slot_t a,
  input  slot_t b,
  output slot_t first,
  output slot_t second
);

  logic swap;

  assign swap   = slot_before(a, b);
  assign first  = swap ? b : a;
  assign second = swap ? a : b;

endmodule

// File: rtl/page_rank_sorter.sv
// Descending odd-even transposition sorter for page-rank values.
// Captures one snapshot, runs N phases, holds the ranking until taken.
module page_rank_sorter
  import page_rank_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input logic              clk,
  input logic              reset,
  page_rank_sorter_if.slave bus
);

  localparam int PW = $clog2(N);

  sort_state_t   state;
  sort_state_t   state_nx;
  logic [PW-1:0] phase;
  logic          last_phase;
  logic          accept;

  slot_t slot_q [N];
  slot_t even_q [N];
  slot_t odd_q  [N];
  slot_t nxt    [N];

  assign last_phase = (phase == PW'(N - 1));
  assign accept     = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < N / 2; k++) begin : g_even
    page_rank_cmp_swap u_cs (
      .a      (slot_q[2*k]),
      .b      (slot_q[2*k+1]),
      .first  (even_q[2*k]),
      .second (even_q[2*k+1])
    );
  end

  for (genvar k = 0; k < N / 2 - 1; k++) begin : g_odd
    page_rank_cmp_swap u_cs (
      .a      (slot_q[2*k+1]),
      .b      (slot_q[2*k+2]),
      .first  (odd_q[2*k+1]),
      .second (odd_q[2*k+2])
    );
  end

  // the end slots sit out odd phases
  assign odd_q[0]   = slot_q[0];
  assign odd_q[N-1] = slot_q[N-1];

  for (genvar i = 0; i < N; i++) begin : g_mux
    assign nxt[i] = phase[0] ? odd_q[i] : even_q[i];
    assign bus.sorted_vals[i*WIDTH +: WIDTH] =
      slot_q[i].value[WIDTH-1:0];
    assign bus.sorted_idx[i*IDXW +: IDXW] =
      slot_q[i].index[IDXW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SORT;
      SORT:    if (last_phase) state_nx = DONE;
      DONE:    if (bus.out_valid && bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (1'b1)
      state == IDLE: bus.in_ready = !reset;
      state == SORT: bus.busy = 1'b1;
      state == DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      unique case (1'b1)
        accept: begin
          phase <= '0;
          for (int i = 0; i < N; i++) begin
            slot_q[i] <= '{
              value: SLOT_VW'(bus.node_vals[i*WIDTH +: WIDTH]),
              index: SLOT_IW'(i)
            };
          end
        end
        state == SORT: begin
          phase <= phase + 1'b1;
          for (int i = 0; i < N; i++) begin
            slot_q[i] <= nxt[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_page_rank_sorter.sv
// Scoreboard bench: N=4 directed cases and N=16 random regression.
// Expected rankings come from a reference insertion sort.
module tb_page_rank_sorter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   b2b = 1'b0;

  typedef struct {
    logic [255:0] v;
    logic [63:0]  i;
    int           acc;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  logic         ovp [2];
  int           last_acc [2];
  logic [255:0] last_v [2];
  logic [63:0]  last_i [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  page_rank_sorter_if #(.N(4), .WIDTH(16), .IDXW(2)) b4 ();
  page_rank_sorter_if #(.N(16), .WIDTH(16), .IDXW(4)) b16 ();

  page_rank_sorter #(.N(4), .WIDTH(16), .IDXW(2)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  page_rank_sorter #(.N(16), .WIDTH(16), .IDXW(4)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16.slave)
  );

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_sort(input logic [255:0] nv, input int n,
                          input int iw, output logic [255:0] sv,
                          output logic [63:0] si);
    logic [15:0] v [16];
    int          ix [16];
    logic [15:0] tv;
    int          ti;
    for (int k = 0; k < n; k++) begin
      v[k] = nv[k*16 +: 16];
      ix[k] = k;
    end
    for (int k = 1; k < n; k++) begin
      for (int j = k; j > 0; j--) begin
        if (v[j] > v[j-1] || (v[j] == v[j-1] && ix[j] < ix[j-1])) begin
          tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
          ti = ix[j]; ix[j] = ix[j-1]; ix[j-1] = ti;
        end
      end
    end
    sv = '0;
    si = '0;
    for (int r = 0; r < n; r++) begin
      sv[r*16 +: 16] = v[r];
      for (int b = 0; b < iw; b++) si[r*iw + b] = ix[r][b];
    end
  endtask

  task automatic observe(input int d, input int n, input int iw,
                         input logic iv, input logic ir,
                         input logic [255:0] nv, input logic ov,
                         input logic ordy, input logic [255:0] sv,
                         input logic [63:0] si);
    exp_t         e;
    logic [255:0] ev;
    logic [63:0]  ei;
    int           qs;
    if (reset) begin
      if (d == 0) q0.delete(); else q1.delete();
      ovp[d] = 1'b0;
      return;
    end
    qs = (d == 0) ? q0.size() : q1.size();
    if (ov && !ovp[d]) begin
      if (qs == 0) check("unexpected_out", 256'(qs), 256'(1));
      else begin
        e = (d == 0) ? q0[0] : q1[0];
        check("latency", 256'(cyc - e.acc), 256'(n + 1));
      end
    end
    if (ov && ordy && qs > 0) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check("sorted_vals", sv, e.v);
      check("sorted_idx", 256'(si), 256'(e.i));
      last_v[d] = sv;
      last_i[d] = si;
    end
    if (iv && ir) begin
      ref_sort(nv, n, iw, ev, ei);
      if (b2b && d == 1 && last_acc[1] >= 0)
        check("b2b_gap", 256'(cyc - last_acc[1]), 256'(n + 2));
      last_acc[d] = cyc;
      if (d == 0) q0.push_back('{ev, ei, cyc});
      else q1.push_back('{ev, ei, cyc});
    end
    ovp[d] = ov;
  endtask

  always @(negedge clk) begin
    observe(0, 4, 2, b4.in_valid, b4.in_ready, 256'(b4.node_vals),
            b4.out_valid, b4.out_ready, 256'(b4.sorted_vals),
            64'(b4.sorted_idx));
    observe(1, 16, 4, b16.in_valid, b16.in_ready, b16.node_vals,
            b16.out_valid, b16.out_ready, b16.sorted_vals,
            64'(b16.sorted_idx));
  end

  task automatic send4(input logic [63:0] v);
    int t = 0;
    while (!b4.in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("send4_ready", 256'(b4.in_ready), 256'(1));
    b4.in_valid = 1'b1;
    b4.node_vals = v;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic drain4();
    int t = 0;
    while (q0.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("drain4", 256'(q0.size()), 256'(0));
  endtask

  task automatic send16(input logic [255:0] v);
    int t = 0;
    while (!b16.in_ready && t < 200) begin
      b16.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1; t++;
    end
    check("send16_ready", 256'(b16.in_ready), 256'(1));
    b16.in_valid = 1'b1;
    b16.node_vals = v;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic drain16();
    int t = 0;
    b16.out_ready = 1'b1;
    while (q1.size() != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("drain16", 256'(q1.size()), 256'(0));
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h4000;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    logic [255:0] rv;
    logic [63:0]  hv;
    logic [7:0]   hi;
    int           t;
    ovp[0] = 1'b0; ovp[1] = 1'b0;
    last_acc[0] = -1; last_acc[1] = -1;
    b4.in_valid = 1'b0; b4.node_vals = '0; b4.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.node_vals = '0; b16.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 256'(b4.in_ready), 256'(0));
    check("rst_out_valid", 256'(b4.out_valid), 256'(0));
    check("rst_busy", 256'(b4.busy), 256'(0));
    check("rst_vals", 256'(b4.sorted_vals), 256'(0));
    check("rst_idx", 256'(b4.sorted_idx), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 256'(b4.in_ready), 256'(1));
    @(posedge clk); #1;

    send4({16'h3000, 16'h2000, 16'h4000, 16'h1000});
    drain4();
    check("dist_vals", 256'(last_v[0]),
          256'({16'h1000, 16'h2000, 16'h3000, 16'h4000}));
    check("dist_idx", 256'(last_i[0]),
          256'({2'd0, 2'd2, 2'd3, 2'd1}));

    send4({4{16'h4000}});
    drain4();
    check("eq_vals", 256'(last_v[0]), 256'({4{16'h4000}}));
    check("eq_idx", 256'(last_i[0]), 256'({2'd3, 2'd2, 2'd1, 2'd0}));

    send4({16'h5000, 16'h2000, 16'h5000, 16'h2000});
    drain4();
    check("tie_vals", 256'(last_v[0]),
          256'({16'h2000, 16'h2000, 16'h5000, 16'h5000}));
    check("tie_idx", 256'(last_i[0]), 256'({2'd2, 2'd0, 2'd3, 2'd1}));

    b4.out_ready = 1'b0;
    send4({16'h8000, 16'h0000, 16'hFFFF, 16'h0001});
    t = 0;
    while (!b4.out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("bp_out_valid", 256'(b4.out_valid), 256'(1));
    hv = b4.sorted_vals;
    hi = b4.sorted_idx;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        b4.in_valid = 1'b1;
        b4.node_vals = 64'h1111_2222_3333_4444;
      end
      if (k == 4) b4.in_valid = 1'b0;
      @(negedge clk);
      check("bp_vals_stable", 256'(b4.sorted_vals), 256'(hv));
      check("bp_idx_stable", 256'(b4.sorted_idx), 256'(hi));
      check("bp_in_ready", 256'(b4.in_ready), 256'(0));
      check("bp_held_valid", 256'(b4.out_valid), 256'(1));
      @(posedge clk); #1;
    end
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_retired", 256'(b4.out_valid), 256'(0));
    check("bp_in_ready_back", 256'(b4.in_ready), 256'(1));
    check("bp_vals", 256'(last_v[0]),
          256'({16'h0000, 16'h0001, 16'h8000, 16'hFFFF}));
    check("bp_idx", 256'(last_i[0]), 256'({2'd2, 2'd0, 2'd3, 2'd1}));
    repeat (8) @(posedge clk);
    #1;
    check("bp_dropped", 256'(b4.out_valid), 256'(0));

    send4({16'h2222, 16'h1111, 16'h4444, 16'h3333});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 256'(b4.out_valid), 256'(0));
    check("abort_busy", 256'(b4.busy), 256'(0));
    check("abort_vals", 256'(b4.sorted_vals), 256'(0));
    check("abort_idx", 256'(b4.sorted_idx), 256'(0));
    @(posedge clk); #1;
    send4({16'h0002, 16'h0004, 16'h0001, 16'h0003});
    drain4();
    check("post_abort_vals", 256'(last_v[0]),
          256'({16'h0001, 16'h0002, 16'h0003, 16'h0004}));
    check("post_abort_idx", 256'(last_i[0]),
          256'({2'd1, 2'd3, 2'd0, 2'd2}));

    for (int s = 0; s < 200; s++) begin
      for (int k = 0; k < 16; k++) rv[k*16 +: 16] = rnd_val();
      send16(rv);
    end
    drain16();

    b2b = 1'b1;
    last_acc[1] = -1;
    b16.out_ready = 1'b1;
    b16.in_valid = 1'b1;
    for (int c = 0; c < 110; c++) begin
      for (int k = 0; k < 16; k++) rv[k*16 +: 16] = rnd_val();
      b16.node_vals = rv;
      @(posedge clk); #1;
    end
    b16.in_valid = 1'b0;
    drain16();
    b2b = 1'b0;

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
